// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: merges a never-stalling ALU result path
// with a valid/ready memory return path. Memory results that lose arbitration
// wait in a small FIFO. ALU writes squash older pending writes to the same rd.
module rf_writeback_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_data,
    output logic             WEN,
    output logic [4:0]       RW,
    output logic [31:0]      busW,
    output logic [PTR_W:0]   pending,
    output logic [7:0]       squash_cnt
);

    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SQ_W   = PTR_W + 2;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [DEPTH-1:0]   vld_d;
    logic [PTR_W-1:0]   rptr_q;
    logic [PTR_W-1:0]   wptr_q;

    logic               alu_grant;
    logic               mem_acc;
    logic               pop;
    logic               push;
    logic               bypass;
    logic               mem_squash;
    logic [SQ_W-1:0]    n_sq;
    logic [CNT_W:0]     sq_sum;
    logic               wen_d;
    logic [RD_W-1:0]    rw_d;
    logic [DATA_W-1:0]  busw_d;

    // Full FIFO refuses new results even if the head pops this cycle.
    assign mem_ready  = (pending < (PTR_W+1)'(DEPTH));

    // Grant and handshake decode.
    assign alu_grant  = alu_valid && (alu_rd != '0);
    assign mem_acc    = mem_valid && mem_ready;
    assign pop        = !alu_grant && (pending != '0);
    assign bypass     = !alu_grant && (pending == '0) && mem_valid && (mem_rd != '0);
    assign mem_squash = mem_acc && (mem_rd != '0) && alu_grant && (mem_rd == alu_rd);
    assign push       = mem_acc && (mem_rd != '0) && !bypass && !mem_squash;
    assign sq_sum     = {1'b0, squash_cnt} + (CNT_W+1)'(n_sq);

    // Entry valid bits: squash by younger ALU write, clear on pop, set on push.
    always_comb begin
        vld_d = vld_q;
        n_sq  = '0;
        if (alu_grant) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld_q[PTR_W'(i)] && (ent_q[PTR_W'(i)].rd == alu_rd)) begin
                    vld_d[PTR_W'(i)] = 1'b0;
                    n_sq             = n_sq + SQ_W'(1);
                end
            end
        end
        if (mem_squash) begin
            n_sq = n_sq + SQ_W'(1);
        end
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wptr_q] = 1'b1;
        end
    end

    // Next write-port value by priority: ALU, FIFO head, bypass, idle.
    always_comb begin
        wen_d  = 1'b0;
        rw_d   = RW;
        busw_d = busW;
        if (alu_grant) begin
            wen_d  = 1'b1;
            rw_d   = alu_rd;
            busw_d = alu_data;
        end else if (pop) begin
            if (vld_q[rptr_q]) begin
                wen_d  = 1'b1;
                rw_d   = ent_q[rptr_q].rd;
                busw_d = ent_q[rptr_q].data;
            end
        end else if (bypass) begin
            wen_d  = 1'b1;
            rw_d   = mem_rd;
            busw_d = mem_data;
        end
    end

    // Write-port output registers.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            WEN  <= 1'b0;
            RW   <= '0;
            busW <= '0;
        end else begin
            WEN  <= wen_d;
            RW   <= rw_d;
            busW <= busw_d;
        end
    end

    // FIFO storage, pointers, occupancy and squash counter.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[PTR_W'(i)] <= '0;
            end
            vld_q      <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            pending    <= '0;
            squash_cnt <= '0;
        end else begin
            vld_q <= vld_d;
            if (push) begin
                ent_q[wptr_q] <= '{rd: mem_rd, data: mem_data};
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   pending <= pending + (PTR_W+1)'(1);
                2'b01:   pending <= pending - (PTR_W+1)'(1);
                default: pending <= pending;
            endcase
            squash_cnt <= (sq_sum > (CNT_W+1)'(255)) ? CNT_W'(255) : sq_sum[CNT_W-1:0];
        end
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side producer for the 32x32 register file. Merges two result sources onto the file's single write port (WEN/RW/busW):
  - a single-cycle ALU path that can never stall;
  - a long-latency memory/load return path with a valid/ready handshake.
- Memory results that lose arbitration wait in a small FIFO.
- Registered outputs connect directly to the register file's WEN, RW and busW inputs.

Parameters:
- DEPTH, 2, number of memory-result FIFO entries (power of two, ≥2).
- PTR_W, 1, FIFO pointer width, equal to log2(DEPTH).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- mem_valid  input  1  memory result offered.
- mem_ready  output  1  arbiter can accept a memory result; combinational, equal to count < DEPTH.
- mem_rd  input  5  memory destination register.
- mem_data  input  32  memory result.
- WEN  output  1  register-file write enable (registered).
- RW  output  5  register-file write address (registered).
- busW  output  32  register-file write data (registered).
- pending  output  PTR_W+1  FIFO occupancy (registered).
- squash_cnt  output  8  saturating count of squashed memory results (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - WEN=0, RW=0, busW=0.
  - FIFO empty: pending=0, read and write pointers 0.
  - squash_cnt=0.
  - mem_ready reads 1 during and after reset.
- Latency: an input granted in cycle N appears on WEN/RW/busW in cycle N+1. At most one write per cycle.
- Memory handshake: a result is accepted when mem_valid && mem_ready. When not accepted, the producer holds mem_rd/mem_data stable.
- Per-cycle grant priority, highest first:
  1. ALU: if alu_valid && alu_rd≠0, then next WEN=1, RW=alu_rd, busW=alu_data.
  2. FIFO head: if no ALU grant and pending>0, pop the head; next WEN=1 with the head's rd/data.
  3. Bypass: if no ALU grant, pending=0, and mem_valid && mem_rd≠0, write the memory result directly (no FIFO push).
  4. Otherwise next WEN=0, and RW/busW hold their previous values.
- alu_valid with alu_rd=0: no write. The cycle counts as "no ALU grant" for priorities 2 and 3.
- Memory result with mem_rd=0: accepted (consumed) and discarded. No push, no write.
- Push: an accepted memory result with rd≠0 that is not bypassed is written to the FIFO tail. The push happens even in the same cycle as an ALU grant.
- Full FIFO: mem_ready=0 whenever pending=DEPTH, even if a pop occurs that cycle. No push-through on full.
- Simultaneous pop and push (pending<DEPTH): both occur, so pending is unchanged. Pointers wrap modulo DEPTH.
- Ordering rule: ALU results are always younger than any buffered or incoming memory result. When an ALU write to rd=R is granted:
  - every valid FIFO entry with rd=R is invalidated. Its later pop produces WEN=0 but still frees the slot.
  - an incoming accepted memory result with rd=R in that same cycle is discarded rather than pushed.
  - squash_cnt increments by the number of results squashed that cycle, saturating at 255.
- Entries never reorder among themselves: memory results are written in acceptance order.
- Reset mid-operation: all buffered entries are lost. Any in-flight output write is cancelled immediately (WEN drops asynchronously).

Test Plan:
- Reset then idle: rst released, no valids for 5 cycles -> WEN=0, RW=0, busW=0, pending=0, mem_ready=1 throughout.
- ALU only: alu_valid, rd=5, data=0x0000_00AA in cycle N -> cycle N+1 WEN=1, RW=5, busW=0x0000_00AA; cycle N+2 WEN=0.
- Bypass plus collision:
  - Cycle 0: mem rd=7, data=0x1234 alone -> written cycle 1.
  - Cycle 2: alu rd=3, data=0x11 together with mem rd=8, data=0x22 -> cycle 3 writes r3=0x11, cycle 4 writes r8=0x22, pending 1 then 0.
- Fill/full:
  - Hold alu_valid with rd=1..4 for 4 cycles while offering mem rd=9,10,11 -> mem_ready=0 after 2 accepts (pending=2), rd=11 held.
  - Once ALU stops: writes r9, r10, r11 in order, mem_ready returns to 1.
- Squash: buffer mem rd=6, data=0x55, then alu rd=6, data=0x66 -> r6 written 0x66 once, squashed entry pops with WEN=0, squash_cnt=1.
- x0 and async reset:
  - alu rd=0 and mem rd=0 -> no WEN.
  - Assert rst mid-stream with pending=2 -> WEN=0 immediately, pending=0; after release no stale writes appear.
